gray_ptr_sync: RTL and testbench
================================

GRAY_PTR_SYNC -- requirements
Module: gray_ptr_sync

Interface
REQ-001 SHALL have parameter PTR_WIDTH, default 7, meaning pointer width in bits (address bits + wrap bit); legal range 2..16.
REQ-002 SHALL have parameter STAGES, default 2, meaning synchronizer flop depth; legal range 2..4; out-of-range values SHALL fail elaboration.
REQ-003 SHALL have port clk, input, 1 bit, meaning the destination-domain clock (the single clock).
REQ-004 SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-005 SHALL have port sclr, input, 1 bit, meaning synchronous clear (FIFO flush), active high.
REQ-006 SHALL have port gray_in, input, PTR_WIDTH bits, meaning the Gray-coded pointer from the source domain, registered there.
REQ-007 SHALL have port gray_out, output, PTR_WIDTH bits, meaning the synchronized Gray pointer.
REQ-008 SHALL have port bin_out, output, PTR_WIDTH bits, meaning the binary equivalent of gray_out, registered.
REQ-009 SHALL have port delta, output, PTR_WIDTH bits, meaning the pointer advance since the previous bin_out value, modulo 2^PTR_WIDTH.
REQ-010 SHALL have port advanced, output, 1 bit, meaning a one-cycle pulse when bin_out changed on this cycle.
REQ-011 SHALL have port skipped, output, 1 bit, meaning a one-cycle pulse when delta > 1 (multiple source increments merged).

Function
REQ-012 SHALL sample gray_in into stage 1 on every rising clk edge; stage n SHALL load stage n-1; gray_out SHALL equal stage STAGES.
REQ-013 SHALL give a gray_in -> gray_out latency of exactly STAGES edges when gray_in is held stable.
REQ-014 SHALL compute gray-to-binary combinationally from gray_out (b[MSB]=g[MSB]; b[i]=b[i+1]^g[i]) and register it into bin_out, for a gray_in -> bin_out latency of STAGES+1 edges.
REQ-015 SHALL, on the edge that loads bin_out, register delta = new_bin - bin_out (old value), truncated to PTR_WIDTH bits, so that wrap from 2^PTR_WIDTH-1 to 0 yields delta=1.
REQ-016 SHALL drive advanced=1 for exactly the cycle after an edge where the new binary value differs from old bin_out, else 0.
REQ-017 SHALL drive skipped=1 exactly when advanced=1 and delta > 1; skipped SHALL never be 1 while advanced=0.
REQ-018 SHALL hold delta=0, advanced=0, skipped=0 on any cycle where bin_out did not change.
REQ-019 SHALL treat delta as an unsigned forward distance; no backward motion is detected or flagged.
REQ-020 SHALL, when sclr=1 at an edge, load all sync stages, bin_out and delta with 0 and force advanced=0 and skipped=0, overriding the new sample; sclr has priority over normal update.
REQ-021 SHALL resume normal sampling on the first edge with sclr=0; the first post-clear nonzero value SHALL report delta relative to 0.
REQ-022 SHALL contain no combinational path from gray_in to any output.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force all sync stages, gray_out, bin_out and delta to 0 and advanced and skipped to 0.
REQ-024 SHALL, on rst_n assertion mid-operation, discard all in-flight samples; after deassertion, behaviour SHALL match REQ-021.

Structure
REQ-025 SHALL place the gray-to-binary and binary-to-gray conversion functions in the shared FIFO package, for reuse by the pointer blocks.
REQ-026 SHALL implement the flop chain as one sub-module, sync_chain (parameters WIDTH, STAGES, same clk/rst_n/sclr), with conversion and delta logic in gray_ptr_sync.
REQ-027 SHALL mark the sync_chain stage registers for synchronizer placement (no logic between stages).

Verification
REQ-028 SHALL cover: reset, then gray_in=7'b0000001 held (STAGES=2) -> gray_out=1 after 2 edges, bin_out=1 and advanced=1, delta=1, skipped=0 after 3 edges.
REQ-029 SHALL cover: gray_in stepping from bin 5 to bin 8 (gray 7'h07 -> 7'h0C) in one destination cycle -> delta=3, advanced=1, skipped=1 for one cycle.
REQ-030 SHALL cover: wrap, bin_out=127 (gray 7'h40) then gray_in=0 -> delta=1, advanced=1, skipped=0, bin_out=0.
REQ-031 SHALL cover: sclr pulsed while bin_out=20 and a new value is in flight -> next cycle all outputs 0, advanced=0; in-flight value then propagates with delta from 0.
REQ-032 SHALL cover: rst_n asserted asynchronously between clk edges with bin_out=33 -> outputs 0 immediately, before the next edge.
REQ-033 SHALL cover: STAGES=4, PTR_WIDTH=5, gray_in=5'b00011 -> gray_out after 4 edges, bin_out=2 after 5 edges, with no earlier change.

Source files
------------

// File: rtl/gray_ptr_sync_pkg.sv
// rtl/gray_ptr_sync_pkg.sv - shared FIFO pointer constants and Gray/binary conversion helpers
package gray_ptr_sync_pkg;

  // Widest pointer any FIFO pointer block may use; helpers operate at this width.
  localparam int PTR_MAX_WIDTH = 16;
  localparam int PTR_MIN_WIDTH = 2;
  localparam int SYNC_MIN_STAGES = 2;
  localparam int SYNC_MAX_STAGES = 4;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  // Narrower pointers are zero-extended by the caller, so the extra MSBs add nothing.
  function automatic logic [PTR_MAX_WIDTH-1:0] gray_to_bin(input logic [PTR_MAX_WIDTH-1:0] g);
    logic [PTR_MAX_WIDTH-1:0] b;
    b[PTR_MAX_WIDTH-1] = g[PTR_MAX_WIDTH-1];
    for (int i = PTR_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to Gray: adjacent-bit XOR, used by the source-side pointer blocks.
  function automatic logic [PTR_MAX_WIDTH-1:0] bin_to_gray(input logic [PTR_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_ptr_sync_sync_chain.sv
// rtl/gray_ptr_sync_sync_chain.sv - multi-flop synchronizer for a Gray-coded pointer bus
module sync_chain
  import gray_ptr_sync_pkg::*;
#(
  parameter int WIDTH  = 7,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Synchronizer depth outside the supported range is a configuration error.
  if (STAGES < SYNC_MIN_STAGES || STAGES > SYNC_MAX_STAGES) begin : g_bad_stages
    $error("sync_chain: STAGES must be in 2..4");
  end

  // Stage registers are flop-to-flop only so placement can keep them adjacent.
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage [STAGES];

  // Shift the sampled pointer down the chain; flush clears every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else if (sclr) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// rtl/gray_ptr_sync.sv - Gray pointer synchronizer with binary decode and advance tracking
module gray_ptr_sync
  import gray_ptr_sync_pkg::*;
#(
  parameter int PTR_WIDTH = 7,
  parameter int STAGES    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclr,
  input  logic [PTR_WIDTH-1:0] gray_in,
  output logic [PTR_WIDTH-1:0] gray_out,
  output logic [PTR_WIDTH-1:0] bin_out,
  output logic [PTR_WIDTH-1:0] delta,
  output logic                 advanced,
  output logic                 skipped
);

  // Pointer width outside what the shared helpers support is a configuration error.
  if (PTR_WIDTH < PTR_MIN_WIDTH || PTR_WIDTH > PTR_MAX_WIDTH) begin : g_bad_width
    $error("gray_ptr_sync: PTR_WIDTH must be in 2..16");
  end

  logic [PTR_WIDTH-1:0] new_bin;
  logic [PTR_WIDTH-1:0] diff;
  logic                 moved;

  sync_chain #(
    .WIDTH  (PTR_WIDTH),
    .STAGES (STAGES)
  ) u_sync_chain (
    .clk   (clk),
    .rst_n (rst_n),
    .sclr  (sclr),
    .din   (gray_in),
    .dout  (gray_out)
  );

  // Decode the synchronized pointer and measure forward distance from the last value.
  always_comb begin
    new_bin = PTR_WIDTH'(gray_to_bin(PTR_MAX_WIDTH'(gray_out)));
    diff    = new_bin - bin_out;
    moved   = (new_bin != bin_out);
  end

  // Register the decoded pointer and its advance status; flush overrides the update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out  <= '0;
      delta    <= '0;
      advanced <= 1'b0;
      skipped  <= 1'b0;
    end else if (sclr) begin
      bin_out  <= '0;
      delta    <= '0;
      advanced <= 1'b0;
      skipped  <= 1'b0;
    end else begin
      bin_out  <= new_bin;
      delta    <= diff;
      advanced <= moved;
      skipped  <= moved && (diff > PTR_WIDTH'(1));
    end
  end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// tb/tb_gray_ptr_sync.sv - scoreboard bench for gray_ptr_sync with a queue-based pointer model
module tb_gray_ptr_sync;

  localparam int W = 7;
  localparam int S = 2;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sclr = 1'b0;
  logic [W-1:0] gray_in = '0;
  logic [W-1:0] gray_out, bin_out, delta;
  logic         advanced, skipped;

  logic         rst4_n = 1'b0;
  logic         sclr4 = 1'b0;
  logic [4:0]   gray_in4 = '0;
  logic [4:0]   gray_out4, bin_out4, delta4;
  logic         advanced4, skipped4;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int g;
    int b;
    int d;
    int a;
    int s;
  } exp_t;

  exp_t exp_q[$];
  int   pipe[$];
  int   m_bin;

  always #5 clk = ~clk;

  gray_ptr_sync #(.PTR_WIDTH(W), .STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclr     (sclr),
    .gray_in  (gray_in),
    .gray_out (gray_out),
    .bin_out  (bin_out),
    .delta    (delta),
    .advanced (advanced),
    .skipped  (skipped)
  );

  gray_ptr_sync #(.PTR_WIDTH(5), .STAGES(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst4_n),
    .sclr     (sclr4),
    .gray_in  (gray_in4),
    .gray_out (gray_out4),
    .bin_out  (bin_out4),
    .delta    (delta4),
    .advanced (advanced4),
    .skipped  (skipped4)
  );

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) & MASK;
  endfunction

  function automatic void chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  // Model: the pointer is a delay line of S binary samples feeding a register of the last value.
  function automatic void model_reset();
    pipe = {};
    for (int i = 0; i < S; i++) pipe.push_back(0);
    m_bin = 0;
  endfunction

  function automatic void model_edge(input int b, input bit clr);
    exp_t e;
    int   nb;
    if (clr) begin
      model_reset();
      e = '{g: 0, b: 0, d: 0, a: 0, s: 0};
    end else begin
      nb = pipe.pop_back();
      pipe.push_front(b);
      e.d = (nb - m_bin) & MASK;
      e.a = (nb != m_bin) ? 1 : 0;
      e.s = (e.a == 1 && e.d > 1) ? 1 : 0;
      e.b = nb;
      e.g = to_gray(pipe[S-1]);
      m_bin = nb;
    end
    exp_q.push_back(e);
  endfunction

  task automatic step(input int b, input bit clr, input bit rn);
    @(negedge clk);
    gray_in = W'(to_gray(b));
    sclr    = clr;
    rst_n   = rn;
    @(posedge clk);
    model_edge(b, clr || !rst_n);
  endtask

  task automatic check_now(input string tag, input int b, input int d, input int a, input int s);
    #1;
    chk({tag, ".bin_out"}, int'(bin_out), b);
    chk({tag, ".delta"}, int'(delta), d);
    chk({tag, ".advanced"}, int'(advanced), a);
    chk({tag, ".skipped"}, int'(skipped), s);
  endtask

  // Monitor: every destination cycle presents a full output set; compare against the model queue.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (int'(gray_out) != e.g || int'(bin_out) != e.b || int'(delta) != e.d ||
          int'(advanced) != e.a || int'(skipped) != e.s) begin
        n_bad++;
        $display("FAIL scoreboard: got g=%0d b=%0d d=%0d a=%0d s=%0d expected g=%0d b=%0d d=%0d a=%0d s=%0d at %0t",
                 gray_out, bin_out, delta, advanced, skipped, e.g, e.b, e.d, e.a, e.s, $time);
      end
    end
  end

  initial begin
    int b;
    int r;
    model_reset();

    // Reset state, then a single increment held.
    step(0, 0, 0);
    step(0, 0, 0);
    check_now("reset", 0, 0, 0, 0);
    chk("reset.gray_out", int'(gray_out), 0);
    step(1, 0, 1);
    step(1, 0, 1);
    #1 chk("first.gray_out_2edges", int'(gray_out), 1);
    chk("first.bin_out_2edges", int'(bin_out), 0);
    step(1, 0, 1);
    check_now("first", 1, 1, 1, 0);
    step(1, 0, 1);
    check_now("first_hold", 1, 0, 0, 0);

    // Merged increments 5 -> 8.
    repeat (4) step(5, 0, 1);
    step(8, 0, 1);
    step(8, 0, 1);
    step(8, 0, 1);
    check_now("skip", 8, 3, 1, 1);
    step(8, 0, 1);
    check_now("skip_after", 8, 0, 0, 0);

    // Wrap 127 -> 0.
    repeat (4) step(127, 0, 1);
    chk("wrap.pre_bin", int'(bin_out), 127);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    check_now("wrap", 0, 1, 1, 0);

    // Flush with a value in flight, then it propagates relative to 0.
    repeat (4) step(20, 0, 1);
    step(25, 0, 1);
    step(25, 1, 1);
    check_now("sclr", 0, 0, 0, 0);
    #1 chk("sclr.gray_out", int'(gray_out), 0);
    step(25, 0, 1);
    step(25, 0, 1);
    step(25, 0, 1);
    check_now("post_sclr", 25, 25, 1, 1);

    // Asynchronous reset between edges.
    repeat (4) step(33, 0, 1);
    chk("async.pre_bin", int'(bin_out), 33);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async.gray_out", int'(gray_out), 0);
    chk("async.bin_out", int'(bin_out), 0);
    chk("async.delta", int'(delta), 0);
    chk("async.advanced", int'(advanced), 0);
    model_reset();
    step(33, 0, 0);
    repeat (3) step(33, 0, 1);
    check_now("post_reset", 33, 33, 1, 1);

    // Randomized pointer traffic with occasional jumps and flushes.
    b = 33;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        step(b, 1, 1);
      end else begin
        if (r < 12) b = $urandom_range(0, MASK);
        else b = (b + $urandom_range(0, 3)) & MASK;
        step(b, 0, 1);
      end
    end
    repeat (4) step(b, 0, 1);

    // Deep, narrow instance: latency of 4 to gray_out and 5 to bin_out.
    @(negedge clk);
    gray_in4 = 5'b00011;
    rst4_n   = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("s4.gray_out_e%0d", e), int'(gray_out4), (e >= 4) ? 3 : 0);
      chk($sformatf("s4.bin_out_e%0d", e), int'(bin_out4), (e >= 5) ? 2 : 0);
      chk($sformatf("s4.advanced_e%0d", e), int'(advanced4), (e == 5) ? 1 : 0);
    end
    chk("s4.delta", int'(delta4), 2);
    chk("s4.skipped", int'(skipped4), 1);

    @(negedge clk);
    chk("scoreboard.drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
